// File: rtl/cfdf_actor_invoke_scheduler.sv
// Enable-check and invoke scheduler for the inner-product CFDF actor.
// Gates firings on the current mode's FIFO rates, handshakes with the firing FSM and tracks mode/count/faults.
module cfdf_actor_invoke_scheduler #(
  parameter int SIZE      = 3,
  parameter int POP_WIDTH = 8,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_in,
  input  logic                 clear_err_in,
  input  logic [POP_WIDTH-1:0] pop_command,
  input  logic [POP_WIDTH-1:0] pop_length,
  input  logic [POP_WIDTH-1:0] pop_data,
  input  logic [POP_WIDTH-1:0] free_out,
  input  logic                 done_in,
  input  logic [1:0]           next_mode_in,
  output logic                 start_out,
  output logic [1:0]           mode_out,
  output logic                 busy_out,
  output logic                 stall_out,
  output logic                 error_out,
  output logic [CNT_WIDTH-1:0] fire_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [POP_WIDTH-1:0] RATE_M1 = POP_WIDTH'(SIZE);

  logic [2:0]           state_reg, state_next;
  logic [1:0]           mode_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic [WD_W-1:0]      wd_reg, wd_next;
  logic                 enabled;

  // Mode 11 is never enabled; CHECK routes it to ERROR before this matters.
  always_comb begin
    enabled = 1'b0;
    case (mode_out)
      2'b00:   enabled = (pop_command >= RATE_M1) && (pop_length >= RATE_M1) &&
                         (pop_data >= RATE_M1);
      2'b01:   enabled = 1'b1;
      2'b10:   enabled = (free_out != '0);
      default: enabled = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_out;
    count_next = fire_count;
    wd_next    = wd_reg;
    case (state_reg)
      S_IDLE: if (run_in) state_next = S_CHECK;
      S_CHECK: begin
        if (!run_in)               state_next = S_IDLE;
        else if (mode_out == 2'b11) state_next = S_ERROR;
        else if (enabled)          state_next = S_FIRE;
      end
      S_FIRE: begin
        wd_next    = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (done_in) begin
          mode_next  = next_mode_in;
          if (fire_count != '1) count_next = fire_count + 1'b1;
          state_next = S_UPDATE;
        end else if ((TIMEOUT > 0) && (wd_reg == WD_LAST)) begin
          state_next = S_ERROR;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      S_UPDATE: begin
        if (mode_out == 2'b11) state_next = S_ERROR;
        else if (run_in)       state_next = S_CHECK;
        else                   state_next = S_IDLE;
      end
      S_ERROR: begin
        if (clear_err_in) begin
          state_next = S_IDLE;
          mode_next  = 2'b00;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of the state just left, so they trail the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      mode_out   <= 2'b00;
      fire_count <= '0;
      wd_reg     <= '0;
      start_out  <= 1'b0;
      busy_out   <= 1'b0;
      stall_out  <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_out   <= mode_next;
      fire_count <= count_next;
      wd_reg     <= wd_next;
      start_out  <= (state_reg == S_FIRE);
      busy_out   <= (state_reg == S_FIRE) || (state_reg == S_WAIT);
      stall_out  <= (state_reg == S_CHECK) && run_in && (mode_out != 2'b11) && !enabled;
      error_out  <= (state_reg == S_ERROR);
    end
  end

endmodule
